// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 32-bit memory between the
// instruction-fetch requester and the load/store requester. Every access is
// sequenced IDLE -> BUSY (WAIT_STATES+1 cycles) -> DONE. The data port has
// priority, and a starvation counter lets fetch win a contested decision after
// STARVE_LIMIT consecutive losses. Misaligned addresses finish with an error
// and never reach the memory.
module mem_port_arbiter #(
    parameter int WAIT_STATES  = 1,  // 0..7
    parameter int STARVE_LIMIT = 3   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    // load/store port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // shared memory
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LP_LAST_WAIT  = 3'(WAIT_STATES);
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_wait_cnt;    // cycles already spent in BUSY
    logic [3:0]  r_starve_cnt;  // consecutive contested losses of fetch
    logic        r_gnt_d;       // 1: current access belongs to the data port
    logic        r_we;          // latched store flag (always 0 for fetch)
    logic        r_err;         // latched misalignment verdict
    logic [31:0] r_addr;        // latched access address
    logic [31:0] r_wdata;       // latched store data
    logic [31:0] r_rdata;       // captured read data for the granted port

    logic        w_decide;      // arbitration happens this cycle
    logic        w_grant_i;     // fetch wins if a decision happens now
    logic        w_misaligned;  // granted address is not word aligned
    logic        w_last_busy;   // final BUSY cycle: strobe write, capture read
    logic [31:0] w_gnt_addr;

    assign w_decide     = (r_state == S_IDLE) && (i_req || d_req);
    assign w_grant_i    = i_req && (!d_req || (r_starve_cnt == LP_STARVE_MAX));
    assign w_gnt_addr   = w_grant_i ? i_addr : d_addr;
    assign w_misaligned = (w_gnt_addr[1:0] != 2'b00);
    assign w_last_busy  = (r_state == S_BUSY) && (r_wait_cnt == LP_LAST_WAIT);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: arbitrate in IDLE, count out BUSY, DONE lasts one cycle.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred when a branch does not update the signal.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_decide) begin
                    w_next_state = w_misaligned ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last_busy) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: memory bus active only in BUSY, ack/err/rdata only in DONE
    // and only towards the port that owns the access.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        i_err     = 1'b0;
        i_rdata   = '0;
        d_ack     = 1'b0;
        d_err     = 1'b0;
        d_rdata   = '0;
        case (r_state)
            S_BUSY: begin
                mem_en    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_we ? r_wdata : '0;
                mem_we    = r_we && w_last_busy;
            end
            S_DONE: begin
                if (r_gnt_d) begin
                    d_ack   = 1'b1;
                    d_err   = r_err;
                    d_rdata = r_rdata;
                end else begin
                    i_ack   = 1'b1;
                    i_err   = r_err;
                    i_rdata = r_rdata;
                end
            end
            default: ;
        endcase
    end

    // Latch the granted request so later changes on the request inputs
    // cannot disturb an access in flight.
    // NOTE: the latched copies are reset too; they feed outputs only through
    // state-gated muxes, but a known value keeps reset behaviour deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_decide) begin
            r_gnt_d <= !w_grant_i;
            if (!w_misaligned) begin
                r_addr  <= w_gnt_addr;
                r_we    <= !w_grant_i && d_we;
                r_wdata <= w_grant_i ? '0 : d_wdata;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    // Wait-state counter: runs 0..WAIT_STATES across BUSY, idles at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_BUSY) && !w_last_busy) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Starvation counter: counts contested decisions lost by fetch, clears
    // whenever fetch wins or is not requesting at a decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_decide) begin
            if (w_grant_i || !i_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt < LP_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Response capture: error verdict at the decision, read data on the final
    // BUSY edge (stores and misaligned accesses report zero data).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_decide) begin
            r_err   <= w_misaligned;
            r_rdata <= '0;
        end else if (w_last_busy) begin
            r_rdata <= r_we ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized two-port traffic,
// checked every cycle against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;

    localparam int WS = 2;  // wait states of the instance under test
    localparam int SL = 3;  // starvation limit of the instance under test

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        i_ack;
        logic        i_err;
        logic [31:0] i_rdata;
        logic        d_ack;
        logic        d_err;
        logic [31:0] d_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } out_t;

    logic [31:0] mem     [64];  // memory seen by the DUT
    logic [31:0] ref_mem [64];  // memory contents the model expects

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model: one access at a time, described by its timeline
    logic        m_active = 1'b0;
    int          m_start;
    int          m_ack_cyc;
    logic        m_port_d;
    logic        m_err;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_starve = 0;

    mem_port_arbiter #(
        .WAIT_STATES (WS),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic out_t actual_outputs();
        out_t o;
        o.i_ack = i_ack;   o.i_err = i_err;   o.i_rdata = i_rdata;
        o.d_ack = d_ack;   o.d_err = d_err;   o.d_rdata = d_rdata;
        o.mem_en = mem_en; o.mem_we = mem_we;
        o.mem_addr = mem_addr; o.mem_wdata = mem_wdata;
        return o;
    endfunction

    // Expected outputs for the current cycle from the access timeline:
    // memory busy for cycles start+1 .. start+WS+1, ack one cycle later.
    function automatic out_t model_expect();
        out_t        e;
        logic [31:0] rd;
        e = '0;
        if (!reset && m_active) begin
            if (!m_err && cyc > m_start && cyc <= m_start + WS + 1) begin
                e.mem_en    = 1'b1;
                e.mem_addr  = m_addr;
                e.mem_wdata = m_we ? m_wdata : 32'h0;
                e.mem_we    = m_we && (cyc == m_start + WS + 1);
            end
            if (cyc == m_ack_cyc) begin
                rd = (m_err || m_we) ? 32'h0 : ref_mem[m_addr[7:2]];
                if (m_port_d) begin
                    e.d_ack = 1'b1; e.d_err = m_err; e.d_rdata = rd;
                end else begin
                    e.i_ack = 1'b1; e.i_err = m_err; e.i_rdata = rd;
                end
            end
        end
        return e;
    endfunction

    task automatic model_decide();
        logic gi;
        gi = i_req && (!d_req || m_starve == SL);
        if (i_req && d_req && !gi) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        else m_starve = 0;
        m_port_d  = !gi;
        m_addr    = gi ? i_addr : d_addr;
        m_we      = !gi && d_we;
        m_wdata   = d_wdata;
        m_err     = (m_addr[1:0] != 2'b00);
        m_start   = cyc;
        m_ack_cyc = m_err ? cyc + 1 : cyc + WS + 2;
        m_active  = 1'b1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("cycle_outputs", actual_outputs(), model_expect());
            if (reset) begin
                m_active = 1'b0;
                m_starve = 0;
            end else if (m_active && cyc == m_ack_cyc) begin
                if (m_we && !m_err) ref_mem[m_addr[7:2]] = m_wdata;
                m_active = 1'b0;  // DONE cycle: no decision here
            end else if (!m_active && (i_req || d_req)) begin
                model_decide();
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {24'h0, 8'($urandom_range(0, 255))};
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic fetch_driver(input int n);
        int gap;
        int b;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                i_req = 1'b0;
                repeat (gap) next_cycle();
            end
            i_req  = 1'b1;
            i_addr = rand_addr();
            b = 0;
            @(negedge clk);
            while (!i_ack && b < 100) begin
                @(negedge clk);
                b++;
            end
            check("fetch_ack_seen", i_ack, 1);
            next_cycle();
        end
        i_req = 1'b0;
    endtask

    task automatic data_driver(input int n);
        int gap;
        int b;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                d_req = 1'b0;
                repeat (gap) next_cycle();
            end
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = rand_addr();
            d_wdata = $urandom;
            b = 0;
            @(negedge clk);
            while (!d_ack && b < 100) begin
                @(negedge clk);
                b++;
            end
            check("data_ack_seen", d_ack, 1);
            next_cycle();
        end
        d_req = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        mem[1]  = 32'h11112222;
        mem[4]  = 32'h00421020;
        mem[8]  = 32'h0BADF00D;
        mem[12] = 32'h5A5A1234;
        for (int k = 0; k < 64; k++) ref_mem[k] = mem[k];

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            compare_loop();
            forever begin
                @(negedge clk);
                if (mem_we === 1'b1) mem[mem_addr[7:2]] = mem_wdata;
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", actual_outputs(), '0);
        next_cycle();
        reset = 1'b0;

        // fetch only: BUSY t0+1..t0+3, ack t0+4
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h10;
        at_cycle(t0 + 1);
        check("fetch_mem_en", mem_en, 1);
        check("fetch_mem_addr", mem_addr, 32'h10);
        at_cycle(t0 + 3);
        check("fetch_no_we", mem_we, 0);
        at_cycle(t0 + 4);
        check("fetch_ack", i_ack, 1);
        check("fetch_rdata", i_rdata, 32'h00421020);
        check("fetch_err", i_err, 0);
        next_cycle();
        i_req = 1'b0;

        // contested: data first (ack t0+4), fetch granted t0+5 (ack t0+9)
        next_cycle();
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        at_cycle(t0 + 4);
        check("contest_d_ack", d_ack, 1);
        check("contest_d_rdata", d_rdata, 32'h11112222);
        check("contest_i_waits", i_ack, 0);
        next_cycle();
        d_req = 1'b0;
        at_cycle(t0 + 6);
        check("contest_i_addr", mem_addr, 32'h20);
        at_cycle(t0 + 9);
        check("contest_i_ack", i_ack, 1);
        check("contest_i_rdata", i_rdata, 32'h0BADF00D);
        next_cycle();
        i_req = 1'b0;

        // starvation: three data wins, then fetch, then data wins again
        next_cycle();
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h24;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        at_cycle(t0 + 4);
        check("starve_d1", d_ack, 1);
        at_cycle(t0 + 9);
        check("starve_d2", d_ack, 1);
        at_cycle(t0 + 14);
        check("starve_d3", d_ack, 1);
        at_cycle(t0 + 16);
        check("starve_i_addr", mem_addr, 32'h24);
        at_cycle(t0 + 19);
        check("starve_i_ack", i_ack, 1);
        check("starve_no_d_ack", d_ack, 0);
        next_cycle();
        i_addr = 32'h28;
        at_cycle(t0 + 24);
        check("starve_cleared_d", d_ack, 1);
        check("starve_cleared_i", i_ack, 0);
        next_cycle();
        d_req = 1'b0;
        at_cycle(t0 + 29);
        check("starve_i_ack2", i_ack, 1);
        next_cycle();
        i_req = 1'b0;

        // store: we only in the last BUSY cycle; inputs changed mid-access
        next_cycle();
        t0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
        at_cycle(t0 + 1);
        check("store_we_c1", mem_we, 0);
        check("store_addr_c1", mem_addr, 32'h8);
        check("store_wdata_c1", mem_wdata, 32'hDEADBEEF);
        d_addr = 32'hC; d_wdata = 32'h12345678;
        at_cycle(t0 + 2);
        check("store_we_c2", mem_we, 0);
        at_cycle(t0 + 3);
        check("store_we_c3", mem_we, 1);
        check("store_addr_c3", mem_addr, 32'h8);
        check("store_wdata_c3", mem_wdata, 32'hDEADBEEF);
        at_cycle(t0 + 4);
        check("store_ack", d_ack, 1);
        check("store_rdata", d_rdata, 0);
        next_cycle();
        t1 = cyc;
        d_we = 1'b0; d_addr = 32'h8;
        at_cycle(t1 + 4);
        check("store_readback", d_rdata, 32'hDEADBEEF);
        next_cycle();
        d_req = 1'b0;

        // misaligned fetch: ack+err next cycle, no memory access
        next_cycle();
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h6;
        at_cycle(t0 + 1);
        check("misalign_ack", i_ack, 1);
        check("misalign_err", i_err, 1);
        check("misalign_rdata", i_rdata, 0);
        check("misalign_no_mem", mem_en, 0);
        next_cycle();
        i_req = 1'b0;

        // reset in first BUSY cycle of a store, then a fresh load
        next_cycle();
        t0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
        at_cycle(t0 + 1);
        check("abort_busy", mem_en, 1);
        #2 reset = 1'b1;
        #1 check("abort_async_clear", actual_outputs(), '0);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        t1 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        at_cycle(t1 + 4);
        check("abort_fresh_ack", d_ack, 1);
        check("abort_mem_intact", d_rdata, 32'h5A5A1234);
        next_cycle();
        d_req = 1'b0;

        // randomized two-port traffic
        next_cycle();
        fork
            fetch_driver(120);
            data_driver(120);
        join
        repeat (6) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port 32-bit instruction/data memory between the pipeline's instruction-fetch requester and its load/store (MEM-stage) requester. The memory's read data is combinational from its address, like the existing ROM/RAM models. The block sequences every access through a small FSM with configurable wait states. It gives the data port priority, with a starvation guard for fetch, and rejects misaligned addresses without touching memory.

Parameters:
WAIT_STATES, 1, extra cycles the address is held before read data is sampled (0..7)
STARVE_LIMIT, 3, consecutive contested losses after which fetch wins the next contested decision (1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
i_req  input  1  fetch request; held with i_addr stable until i_ack
i_addr  input  32  fetch byte address
i_ack  output  1  one-cycle completion pulse for fetch
i_rdata  output  32  registered fetch data, valid while i_ack=1
i_err  output  1  with i_ack: misaligned address, no access made
d_req  input  1  data request; held with d_addr/d_we/d_wdata stable until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_ack  output  1  one-cycle completion pulse for data
d_rdata  output  32  registered load data (0 for stores), valid while d_ack=1
d_err  output  1  with d_ack: misaligned address, no access made
mem_en  output  1  memory access in progress
mem_addr  output  32  address to memory
mem_we  output  1  write strobe
mem_wdata  output  32  write data to memory
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset values: FSM=IDLE; wait counter=0; starvation counter=0. All outputs are 0: acks, errs, rdata, mem_en, mem_addr, mem_we, mem_wdata.
- FSM states are IDLE, BUSY, DONE. Arbitration happens only in IDLE.
- IDLE decision:
  - Only one req high: grant it.
  - Both high: grant data, unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
  - Granted address has addr[1:0]!=0: go directly to DONE with the err bit set and rdata=0, no memory access. Otherwise go to BUSY and latch the granted requester's addr, we and wdata.
- Starvation counter: increments when both are requesting and data is granted. It clears when fetch is granted or when i_req=0 at a decision. It saturates at STARVE_LIMIT.
- BUSY lasts WAIT_STATES+1 cycles, counted by the wait counter:
  - mem_en=1 and mem_addr=latched address throughout. mem_wdata=latched data for stores, else 0.
  - mem_we=1 only in the final BUSY cycle, and only for stores.
  - On the final-cycle edge, mem_rdata is captured into the granted port's rdata (loads and fetches; stores capture 0). The FSM moves to DONE.
- DONE lasts exactly one cycle:
  - The granted port's ack=1, and err is as decided.
  - The other port's ack, err and rdata stay 0.
  - No arbitration occurs in DONE, so a requester whose req is still high during its ack cycle is not re-granted for the same access.
  - Next state is IDLE.
- Latency: req high in IDLE cycle n, uncontested → ack in cycle n+WAIT_STATES+2. Minimum issue interval per access is WAIT_STATES+3 cycles.
- In IDLE/DONE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. rdata outputs are 0 whenever the corresponding ack=0.
- Inputs changing while their request is being serviced are ignored (latched copy used). Dropping req during BUSY does not abort the access; ack is still issued.
- Reset asserted in any state: immediately IDLE, all outputs 0, counters 0. A store interrupted before its final BUSY cycle never asserts mem_we.

Test Plan:
- Fetch only, WAIT_STATES=1, i_addr=0x10, memory returns 0x00421020 at 0x10 → mem_en cycles 1-2, i_ack cycle 3 with i_rdata=0x00421020, i_err=0.
- i_req and d_req both high from cycle 0, d load 0x4 → d_ack first (cycle 3); fetch then granted in cycle 4 IDLE, i_ack cycle 7.
- d_req held continuously with i_req held, STARVE_LIMIT=3 → three data accesses complete, then fourth grant goes to fetch; counter returns to 0.
- Store d_addr=0x8, d_wdata=0xDEADBEEF, WAIT_STATES=2 → mem_we high only in the 3rd BUSY cycle with mem_addr=0x8; d_ack with d_rdata=0.
- i_addr=0x6 → no mem_en at any cycle; i_ack and i_err both high in cycle 1, i_rdata=0.
- Reset raised during the first BUSY cycle of a store → mem_we never high, no ack, all outputs 0. After release, a fresh request completes normally.
